gray_bin_pipe: RTL and testbench
================================

GRAY_BIN_PIPE -- requirements
Module: gray_bin_pipe

Interface
REQ-001 Parameter: WIDTH, default 5, code width in bits (legal 2..32).
REQ-002 Parameter: STAGES, default 2, pipeline depth in cycles (legal 1..4).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  din/mode valid this cycle.
REQ-006 in_ready  output  1  block accepts din this cycle.
REQ-007 mode  input  1  0 = gray->binary, 1 = binary->gray; sampled with din.
REQ-008 din  input  WIDTH  code word to convert.
REQ-009 out_valid  output  1  dout/mode_o valid.
REQ-010 out_ready  input  1  downstream accepts dout.
REQ-011 dout  output  WIDTH  converted word.
REQ-012 mode_o  output  1  mode that accompanied dout.
REQ-013 err  output  1  gray-adjacency error flag (see Configuration).

Function
REQ-014 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-015 Gray->binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 downto 0.
REQ-016 Binary->gray: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] XOR b[i].
REQ-017 Conversion is complete within stage 1; stages 2..STAGES carry data, mode and valid unchanged.
REQ-018 Latency: a word accepted in cycle N appears on dout with out_valid in cycle N+STAGES when there is no stall.
REQ-019 Stall: stall = out_valid && !out_ready; in_ready = !stall.
REQ-020 During a stall, every stage holds data, mode and valid unchanged.
REQ-021 When not stalled, each stage loads its predecessor; stage 1 loads valid = in_valid && in_ready.
REQ-022 Empty stages (valid = 0) advance even when a later stage is valid; bubbles are not compressed.
REQ-023 No word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 Throughput: one word per cycle while out_ready = 1.
REQ-025 Simultaneous acceptance of a new input and release of the output in the same cycle is legal and required.
REQ-026 dout and mode_o are don't-care while out_valid = 0; each stage register holds its last value.

Reset
REQ-027 On rst = 1 at a clock edge:
  - all stage valid bits clear to 0;
  - all stage data and mode registers clear to 0;
  - out_valid = 0, dout = 0, mode_o = 0, err = 0;
  - the adjacency history is invalidated.
REQ-028 in_ready is 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-stream discards all in-flight words; no stale word is emitted afterwards.

Configuration
REQ-030 Macro GRAY_ADJ_CHECK_EN enables the adjacency checker; without it, err is tied to 0 and no history registers exist.
REQ-031 With the macro, the block keeps the last accepted mode-0 din and a history-valid bit.
  - The history-valid bit is cleared by reset.
  - A mode-1 input leaves the history unchanged.
REQ-032 With the macro, err travels with the word and is asserted alongside out_valid when both hold:
  - the word is mode 0 and history is valid;
  - the Hamming distance between din and the previous mode-0 din is not exactly 1.
  The first mode-0 word after reset never flags.

Verification
REQ-033 WIDTH=5, STAGES=2, mode=0, din=5'b01101 at cycle 0 -> dout=5'b01001, out_valid=1, mode_o=0 at cycle 2.
REQ-034 mode=1, din=5'b01001 -> dout=5'b01101; mode=0, din=5'b11111 -> dout=5'b10101.
REQ-035 Streaming gray inputs 0..31 in sequence with out_ready held at 0 for cycles 4-7 -> all 32 words appear in order, none lost; in_ready=0 exactly while stalled.
REQ-036 Assert rst for one cycle with 2 words in flight -> out_valid=0 on the next cycle; no stale word is ever emitted.
REQ-037 Macro defined: mode-0 inputs 5'b00000 then 5'b00011 -> err=1 with the second word; 5'b00000 then 5'b00001 -> err=0.
REQ-038 Macro undefined: the same stimulus as REQ-037 -> err=0 throughout.
REQ-039 Exhaustive check at WIDTH=8, both modes: binary->gray followed by gray->binary returns the original value for all 256 inputs.

Source files
------------

// File: rtl/gray_bin_pipe.sv
// Gray<->binary converter with a valid/ready pipeline of STAGES registers.
// Define GRAY_ADJ_CHECK_EN to add the gray-adjacency error checker on mode-0 words.
module gray_bin_pipe #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             mode_o,
  output logic             err
);

  logic             stall;
  logic [WIDTH-1:0] conv_d;
  logic             vld_q  [STAGES];
  logic             mode_q [STAGES];
  logic [WIDTH-1:0] data_q [STAGES];

  assign stall    = vld_q[STAGES-1] && !out_ready;
  assign in_ready = !stall;

  // Gray->binary bit i is the XOR of all gray bits at or above i (prefix XOR by shifts).
  always_comb begin
    conv_d = din ^ (din >> 1);
    if (!mode) begin
      conv_d = din;
      for (int unsigned k = 1; k < WIDTH; k++) begin
        conv_d = conv_d ^ (din >> k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        mode_q[s] <= 1'b0;
        data_q[s] <= '0;
      end
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        data_q[0] <= conv_d;
        mode_q[0] <= mode;
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          data_q[s] <= data_q[s-1];
          mode_q[s] <= mode_q[s-1];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign dout      = data_q[STAGES-1];
  assign mode_o    = mode_q[STAGES-1];

`ifdef GRAY_ADJ_CHECK_EN
  logic             accept;
  logic             err_q [STAGES];
  logic [WIDTH-1:0] hist_q;
  logic             hist_vld_q;
  logic [WIDTH-1:0] diff;
  logic             adj_err;

  assign accept  = in_valid && !stall;
  assign diff    = din ^ hist_q;
  // Exactly one differing bit <=> diff nonzero and a power of two.
  assign adj_err = !mode && hist_vld_q &&
                   !((diff != '0) && ((diff & (diff - {{(WIDTH-1){1'b0}}, 1'b1})) == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        err_q[s] <= 1'b0;
      end
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
    end else begin
      if (!stall) begin
        err_q[0] <= in_valid && adj_err;
        for (int unsigned s = 1; s < STAGES; s++) begin
          err_q[s] <= err_q[s-1];
        end
      end
      if (accept && !mode) begin
        hist_q     <= din;
        hist_vld_q <= 1'b1;
      end
    end
  end

  assign err = vld_q[STAGES-1] && err_q[STAGES-1];
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_bin_pipe.sv
// Scoreboard bench for gray_bin_pipe: directed vectors, stall stream, mid-stream reset,
// adjacency flag, and an 8-bit round-trip sweep on a second instance.
module tb_gray_bin_pipe;
  localparam int unsigned W = 5;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, mode, out_valid, out_ready, mode_o, err;
  logic [W-1:0] din, dout;

  logic       b_in_valid, b_in_ready, b_mode, b_out_valid, b_mode_o, b_err;
  logic [7:0] b_din, b_dout;

  always #5 clk = ~clk;

  gray_bin_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .din(din), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .mode_o(mode_o), .err(err)
  );

  gray_bin_pipe #(.WIDTH(8), .STAGES(3)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
    .din(b_din), .out_valid(b_out_valid), .out_ready(1'b1), .dout(b_dout),
    .mode_o(b_mode_o), .err(b_err)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         m;
    logic         e;
    int unsigned  acc;
    logic         lat;
  } exp_t;

  exp_t        sb[$];
  logic [8:0]  sb8[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        lat_en = 1'b0;
  logic        rdy_chk_en = 1'b0;
  logic [W-1:0] hist = '0;
  logic         hist_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] exp);
    exp_t e;
    logic ee;
    int   guard;
    @(negedge clk);
    in_valid = 1'b1; mode = m; din = d;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    ee = 1'b0;
`ifdef GRAY_ADJ_CHECK_EN
    if (!m) begin
      ee = hist_v && ($countones(d ^ hist) != 1);
      hist = d;
      hist_v = 1'b1;
    end
`endif
    e = '{d: exp, m: m, e: ee, acc: cyc, lat: lat_en};
    sb.push_back(e);
  endtask

  task automatic send8(input logic m, input logic [7:0] d, input logic [7:0] exp);
    int guard;
    @(negedge clk);
    b_in_valid = 1'b1; b_mode = m; b_din = d;
    #1;
    guard = 0;
    while (!b_in_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("in_ready8_timeout", {31'b0, b_in_ready}, 32'd1);
    @(posedge clk);
    sb8.push_back({m, exp});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  // Monitor for the 5-bit instance.
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("dout", {27'b0, dout}, {27'b0, e.d});
        check("mode_o", {31'b0, mode_o}, {31'b0, e.m});
        check("err", {31'b0, err}, {31'b0, e.e});
        if (e.lat) check("latency", cyc - e.acc, S);
      end
    end
    if (rdy_chk_en) check("in_ready_vs_stall", {31'b0, in_ready}, {31'b0, out_ready});
  end

  // Monitor for the 8-bit instance.
  always begin
    logic [8:0] x;
    @(negedge clk); #2;
    if (rst === 1'b0 && b_out_valid === 1'b1) begin
      if (sb8.size() == 0) begin
        check("unexpected_word8", {31'b0, b_out_valid}, 32'd0);
      end else begin
        x = sb8.pop_front();
        check("dout8", {24'b0, b_dout}, {24'b0, x[7:0]});
        check("mode_o8", {31'b0, b_mode_o}, {31'b0, x[8]});
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; din = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_mode = 1'b0; b_din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_dout", {27'b0, dout}, 32'd0);
    check("rst_mode_o", {31'b0, mode_o}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed conversions with latency checks.
    lat_en = 1'b1;
    send(1'b0, 5'b01101, 5'b01001);
    idle();
    repeat (3) @(negedge clk);
    send(1'b1, 5'b01001, 5'b01101);
    send(1'b0, 5'b11111, 5'b10101);
    send(1'b1, 5'b11111, 5'b10000);
    send(1'b0, 5'b10000, 5'b11111);
    idle();
    repeat (4) @(negedge clk);
    lat_en = 1'b0;

    // Stream gray 0..31 with a four-cycle output stall.
    fork
      begin
        for (int k = 0; k < 32; k++) send(1'b0, W'(k), g2b(W'(k)));
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0; rdy_chk_en = 1'b1;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rdy_chk_en = 1'b0;
      end
    join
    repeat (5) @(negedge clk);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(1'b0, 5'b00110, 5'b00100);
    send(1'b1, 5'b00110, 5'b00101);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("out_valid_after_rst", {31'b0, out_valid}, 32'd0);
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    sb.delete();
    hist_v = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Adjacency sequence (first word after reset never flags).
    send(1'b0, 5'b00000, 5'b00000);
    send(1'b0, 5'b00011, 5'b00010);
    send(1'b1, 5'b10101, 5'b11111);
    send(1'b0, 5'b00000, 5'b00000);
    send(1'b0, 5'b00001, 5'b00001);
    idle();
    repeat (5) @(negedge clk);

    // 8-bit round trip: binary->gray then gray->binary back to the original.
    for (int v = 0; v < 256; v++) send8(1'b1, 8'(v), 8'(v) ^ (8'(v) >> 1));
    for (int v = 0; v < 256; v++) send8(1'b0, 8'(v) ^ (8'(v) >> 1), 8'(v));
    idle();

    guard = 0;
    while ((sb.size() != 0 || sb8.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size() + sb8.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
